// File: rtl/klp32_run_ctrl.sv
// Purpose: execution controller for the KLP32 core; free-run / single-step clock enable, PC breakpoint, probe snapshot.
// Latency: free-run cpu_ce once every CLK_DIV cycles; a debounced press gives cpu_ce on the following cycle.
// Backpressure: none; cpu_ce is a one-cycle enable with no handshake, and probe_out simply holds between loads.
module klp32_run_ctrl #(
  parameter int CLK_DIV         = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 16,
  parameter int NUM_PROBES      = 16,
  parameter int PROBE_W         = 32
) (
  input  logic                            clk,
  input  logic                            reset_in,
  input  logic                            run_mode,
  input  logic                            step_btn,
  input  logic                            bp_en,
  input  logic [PROBE_W-1:0]              bp_addr,
  input  logic [PROBE_W-1:0]              pc_in,
  input  logic [$clog2(NUM_PROBES)-1:0]   probe_sel,
  input  logic [NUM_PROBES*PROBE_W-1:0]   probe_bus,
  output logic                            cpu_ce,
  output logic                            cpu_reset,
  output logic                            halted,
  output logic [31:0]                     step_count,
  output logic [PROBE_W-1:0]              probe_out
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);

  localparam logic [1:0] ST_RST_WAIT  = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STEP_IDLE = 2'd2;
  localparam logic [1:0] ST_HALT      = 2'd3;

  // synchroniser stages
  logic btn_meta;
  logic btn_sync;
  logic mode_meta;
  logic mode_sync;

  // debouncer
  logic            btn_db;
  logic [DB_W-1:0] db_cnt;
  logic            btn_diff;
  logic            press;

  // control
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              step_pend;
  logic              ce_d;
  logic              run_pulse;
  logic              bp_hit;

  // probe snapshot
  logic [$clog2(NUM_PROBES)-1:0] sel_q;
  logic                          sel_chg;
  logic [PROBE_W-1:0]            chan_dat;

  // Two-flop synchronisers; the button idles released (1), the mode idles in step mode (0).
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      mode_meta <= 1'b0;
      mode_sync <= 1'b0;
    end else begin
      btn_meta  <= step_btn;
      btn_sync  <= btn_meta;
      mode_meta <= run_mode;
      mode_sync <= mode_meta;
    end
  end

  // A new button level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  assign btn_diff = (btn_sync != btn_db);
  assign press    = btn_diff && (db_cnt == DB_LAST) && !btn_sync;

  // Debounce counter restarts on any cycle where the sample agrees with the accepted level.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_diff) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // The breakpoint is only looked at in the cycle after a pulse, when the core has just advanced.
  assign bp_hit = ce_d && bp_en && (pc_in == bp_addr);

  // A divider pulse is dropped in the cycle the synchronised mode falls back to step.
  assign run_pulse = (state == ST_RUN) && (div_cnt == DIV_LAST) && mode_sync;

  // reset_in gates the enable directly so a pulse can never coincide with a reset cycle.
  assign cpu_ce = reset_in && (step_pend || run_pulse);

  assign halted = (state == ST_HALT);

  // Next-state selection; a breakpoint hit outranks any mode change.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST_WAIT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = mode_sync ? ST_RUN : ST_STEP_IDLE;
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          state_nxt = ST_HALT;
        end else if (!mode_sync) begin
          state_nxt = ST_STEP_IDLE;
        end
      end
      ST_STEP_IDLE: begin
        if (bp_hit) begin
          state_nxt = ST_HALT;
        end else if (mode_sync) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        // Leaving HALT needs the mode to drop to step first; a steady run level keeps us here.
        if (bp_hit) begin
          state_nxt = ST_HALT;
        end else if (!mode_sync) begin
          state_nxt = ST_STEP_IDLE;
        end
      end
      default: state_nxt = ST_RST_WAIT;
    endcase
  end

  // State, reset hold, divider and step request registers.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state     <= ST_RST_WAIT;
      hold_cnt  <= '0;
      cpu_reset <= 1'b1;
      div_cnt   <= '0;
      step_pend <= 1'b0;
      ce_d      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ce_d      <= cpu_ce;
      cpu_reset <= (state_nxt == ST_RST_WAIT);
      // Presses are ignored while waiting out the reset hold and while free-running.
      step_pend <= press && ((state == ST_STEP_IDLE) || (state == ST_HALT));
      if ((state == ST_RST_WAIT) && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      // The divider only runs while staying in RUN, so every entry starts from zero.
      if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end
    end
  end

  // Pulse counter, free to wrap at 32 bits.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      step_count <= '0;
    end else begin
      step_count <= step_count + {31'd0, cpu_ce};
    end
  end

  // Channel mux; any select beyond the last channel falls back to channel 0.
  always_comb begin
    chan_dat = probe_bus[PROBE_W-1:0];
    for (int k = 0; k < NUM_PROBES; k++) begin
      if (int'(probe_sel) == k) begin
        chan_dat = probe_bus[k*PROBE_W +: PROBE_W];
      end
    end
  end

  // Snapshot the selected channel after each pulse and after each select change.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      sel_q     <= '0;
      sel_chg   <= 1'b0;
      probe_out <= '0;
    end else begin
      sel_q   <= probe_sel;
      sel_chg <= (probe_sel != sel_q);
      if (ce_d || sel_chg) begin
        probe_out <= chan_dat;
      end
    end
  end

endmodule

// File: tb/tb_klp32_run_ctrl.sv
// Directed bench for klp32_run_ctrl with a pulse scoreboard: each expected cpu_ce
// pushes the step_count it should produce; the monitor pops on every pulse.
module tb_klp32_run_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int DEB        = 3;
  localparam int RST_HOLD   = 2;
  localparam int NP         = 4;
  localparam int PW         = 32;

  logic             clk = 1'b0;
  logic             reset_in;
  logic             run_mode;
  logic             step_btn;
  logic             bp_en;
  logic [PW-1:0]    bp_addr;
  logic [PW-1:0]    pc_in;
  logic [1:0]       probe_sel;
  logic [NP*PW-1:0] probe_bus;
  logic             cpu_ce;
  logic             cpu_reset;
  logic             halted;
  logic [31:0]      step_count;
  logic [PW-1:0]    probe_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp  = '0;
  bit          mon_pend = 1'b0;
  logic        prev_ce  = 1'b0;

  klp32_run_ctrl #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .RST_HOLD(RST_HOLD),
    .NUM_PROBES(NP),
    .PROBE_W(PW)
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .run_mode(run_mode),
    .step_btn(step_btn),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .pc_in(pc_in),
    .probe_sel(probe_sel),
    .probe_bus(probe_bus),
    .cpu_ce(cpu_ce),
    .cpu_reset(cpu_reset),
    .halted(halted),
    .step_count(step_count),
    .probe_out(probe_out)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every pulse must be expected, never back-to-back, and bump step_count as predicted.
  always @(negedge clk) begin
    if (mon_pend) begin
      mon_pend = 1'b0;
      checks++;
      assert (step_count === mon_exp) else begin
        failures++;
        $error("FAIL sb_step_count observed=%h expected=%h", step_count, mon_exp);
      end
    end
    if (cpu_ce === 1'b1) begin
      checks++;
      assert ((exp_q.size() != 0) && (prev_ce !== 1'b1)) else begin
        failures++;
        $error("FAIL unexpected_ce observed=1 expected=0 time=%0t", $time);
      end
      if (exp_q.size() != 0) begin
        mon_exp  = exp_q.pop_front();
        mon_pend = 1'b1;
      end
    end
    prev_ce = cpu_ce;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ce(input string tag, input int limit);
    int n;
    n = 0;
    while ((cpu_ce !== 1'b1) && (n < limit)) begin
      tick(1);
      n++;
    end
    checks++;
    assert (cpu_ce === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=no_pulse expected=pulse within %0d cycles", tag, limit);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in  = 1'b0;
    run_mode  = 1'b1;
    step_btn  = 1'b1;
    bp_en     = 1'b1;
    bp_addr   = 32'h10;
    pc_in     = 32'h0;
    probe_sel = 2'd0;
    probe_bus = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};

    // Reset values
    @(negedge clk);
    tick(3);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_step_count", step_count, 32'd0);
    chk("rst_probe_out", probe_out, 32'd0);

    // Reset hold then free-run pulses every CLK_DIV cycles
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    reset_in = 1'b1;
    tick(1);
    chk("hold_c1", {31'd0, cpu_reset}, 32'd1);
    tick(1);
    chk("hold_c2", {31'd0, cpu_reset}, 32'd1);
    tick(1);
    chk("hold_release", {31'd0, cpu_reset}, 32'd0);
    chk("run_entry_ce", {31'd0, cpu_ce}, 32'd0);
    tick(2);
    chk("run_div2_ce", {31'd0, cpu_ce}, 32'd0);
    tick(1);
    chk("run_pulse1", {31'd0, cpu_ce}, 32'd1);
    tick(3);
    chk("run_gap_ce", {31'd0, cpu_ce}, 32'd0);
    tick(1);
    chk("run_pulse2", {31'd0, cpu_ce}, 32'd1);
    tick(4);
    chk("run_pulse3", {31'd0, cpu_ce}, 32'd1);
    pc_in = 32'h10;

    // Breakpoint halt, then a single step-over from HALT
    tick(2);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    tick(1);
    chk("bp_step_count", step_count, 32'd3);
    tick(12);
    chk("halt_holds", {31'd0, halted}, 32'd1);
    exp_q.push_back(32'd4);
    pc_in = 32'h14;
    step_btn = 1'b0;
    tick(8);
    step_btn = 1'b1;
    tick(10);
    chk("stepover_halted", {31'd0, halted}, 32'd1);
    chk("stepover_sb_empty", exp_q.size(), 32'd0);

    // Resume: mode 0 clears halt, mode 1 restarts free-run
    run_mode = 1'b0;
    tick(4);
    chk("resume_unhalt", {31'd0, halted}, 32'd0);
    exp_q.push_back(32'd5);
    run_mode = 1'b1;
    wait_ce("resume_ce", 20);
    run_mode = 1'b0;
    tick(6);
    chk("resume_count", step_count, 32'd5);

    // Single-step: a short glitch is rejected, a bouncy press gives one pulse
    step_btn = 1'b0;
    tick(2);
    step_btn = 1'b1;
    tick(10);
    chk("glitch_no_step", step_count, 32'd5);
    exp_q.push_back(32'd6);
    step_btn = 1'b0;
    tick(3);
    step_btn = 1'b1;
    tick(1);
    step_btn = 1'b0;
    tick(6);
    step_btn = 1'b1;
    tick(12);
    chk("bounce_one_step", step_count, 32'd6);
    chk("bounce_sb_empty", exp_q.size(), 32'd0);

    // Probe snapshot on select change; hold while the channel moves without a pulse
    probe_sel = 2'd2;
    tick(2);
    chk("probe_sel2", probe_out, 32'hDEADBEEF);
    probe_sel = 2'd3;
    tick(2);
    chk("probe_sel3", probe_out, 32'h33333333);
    probe_bus[127:96] = 32'h44444444;
    tick(4);
    chk("probe_hold", probe_out, 32'h33333333);

    // step_count wrap; the same pulse refreshes the probe snapshot
    force dut.step_count = 32'hFFFFFFFF;
    tick(2);
    release dut.step_count;
    exp_q.push_back(32'd0);
    step_btn = 1'b0;
    wait_ce("wrap_ce", 20);
    tick(1);
    chk("wrap_count", step_count, 32'd0);
    tick(1);
    chk("probe_after_ce", probe_out, 32'h44444444);
    step_btn = 1'b1;
    tick(10);

    // One-cycle reset in RUN while the divider sits at its last count
    exp_q.push_back(32'd1);
    run_mode = 1'b1;
    wait_ce("run2_ce", 20);
    tick(3);
    @(posedge clk);
    #1 reset_in = 1'b0;
    @(negedge clk);
    chk("midrst_ce_suppressed", {31'd0, cpu_ce}, 32'd0);
    @(posedge clk);
    #1 reset_in = 1'b1;
    @(negedge clk);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_step_count", step_count, 32'd0);
    chk("midrst_probe_out", probe_out, 32'd0);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    exp_q.push_back(32'd1);
    tick(1);
    chk("midrst_hold_c1", {31'd0, cpu_reset}, 32'd1);
    tick(1);
    chk("midrst_hold_c2", {31'd0, cpu_reset}, 32'd1);
    tick(1);
    chk("midrst_release", {31'd0, cpu_reset}, 32'd0);
    tick(3);
    chk("midrst_first_pulse", {31'd0, cpu_ce}, 32'd1);
    tick(3);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
